branch_resolver: RTL and testbench

ID-stage branch/jump resolution unit for the 5-stage MIPS pipeline. It consumes the ID-stage equality flag from the register comparator and decides taken/not-taken, target address, and IF/ID flush. A small stall state machine holds the front end while a branch operand is still being produced in EX or MEM. It also keeps branch statistics counters for the debug display.

---
 rtl/branch_resolver_pkg.sv | 33 +++
 rtl/branch_hazard_detect.sv | 40 ++++
 rtl/branch_resolver.sv | 150 +++++++++++++++
 tb/tb_branch_resolver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared encodings and operand-use helpers for the ID-stage branch resolver
package branch_resolver_pkg;

  localparam int BR_WIDTH     = 32;
  localparam int BR_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_BLTZ = 3'd6,
    BR_J    = 3'd7
  } br_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

  // jr reads rs; every conditional branch reads rs; plain j/jal reads nothing
  function automatic logic op_reads_rs(input logic [2:0] op, input logic jump_reg);
    return jump_reg || ((op != BR_NONE) && (op != BR_J));
  endfunction

  // Only the two-register compares need rt
  function automatic logic op_reads_rt(input logic [2:0] op, input logic jump_reg);
    return !jump_reg && ((op == BR_BEQ) || (op == BR_BNE));
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// rtl/branch_hazard_detect.sv - stall-cycle count for a branch operand still in flight in EX or MEM
module branch_hazard_detect
  import branch_resolver_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic       jump_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       idex_regwrite,
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic       exmem_memread,
  input  logic [4:0] exmem_rd,
  output logic [1:0] stall_count
);

  logic use_rs;
  logic use_rt;
  logic idex_hit;
  logic exmem_hit;

  // A load in EX costs two cycles, any other pending producer costs one; r0 never hazards
  always_comb begin
    use_rs    = op_reads_rs(branch_op, jump_reg);
    use_rt    = op_reads_rt(branch_op, jump_reg);
    idex_hit  = (idex_rd != 5'd0) &&
                ((use_rs && (idex_rd == id_rs)) || (use_rt && (idex_rd == id_rt)));
    exmem_hit = (exmem_rd != 5'd0) &&
                ((use_rs && (exmem_rd == id_rs)) || (use_rt && (exmem_rd == id_rt)));
    stall_count = 2'd0;
    if (idex_memread && idex_hit) begin
      stall_count = 2'd2;
    end else if (idex_regwrite && idex_hit) begin
      stall_count = 2'd1;
    end else if (exmem_memread && exmem_hit) begin
      stall_count = 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - ID-stage branch/jump resolution with operand stall FSM and statistics
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int WIDTH     = BR_WIDTH,
  parameter int CNT_WIDTH = BR_CNT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [2:0]           BranchOp,
  input  logic                 JumpReg,
  input  logic                 Equal,
  input  logic [WIDTH-1:0]     RsData,
  input  logic [WIDTH-1:0]     PCPlus4,
  input  logic [WIDTH-1:0]     Imm,
  input  logic [25:0]          JTarget,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 IDEX_RegWrite,
  input  logic                 IDEX_MemRead,
  input  logic [4:0]           IDEX_Rd,
  input  logic                 EXMEM_MemRead,
  input  logic [4:0]           EXMEM_Rd,
  output logic                 Stall,
  output logic                 PCSrc,
  output logic [WIDTH-1:0]     BranchTarget,
  output logic                 Flush,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] TakenCount
);

  br_state_e        state;
  br_state_e        state_next;
  logic [1:0]       remain;
  logic [1:0]       remain_next;
  logic [1:0]       stall_count;
  logic             active;
  logic             cond_taken;
  logic             resolve;
  logic [WIDTH-1:0] target;
  br_op_e           op;

  assign op     = br_op_e'(BranchOp);
  assign active = (BranchOp != 3'd0) || JumpReg;

  branch_hazard_detect u_hazard (
    .branch_op     (BranchOp),
    .jump_reg      (JumpReg),
    .id_rs         (ID_Rs),
    .id_rt         (ID_Rt),
    .idex_regwrite (IDEX_RegWrite),
    .idex_memread  (IDEX_MemRead),
    .idex_rd       (IDEX_Rd),
    .exmem_memread (EXMEM_MemRead),
    .exmem_rd      (EXMEM_Rd),
    .stall_count   (stall_count)
  );

  // Branch condition and redirect address for the instruction sitting in ID
  always_comb begin
    cond_taken = 1'b0;
    target     = PCPlus4 + (Imm << 2);
    if (JumpReg) begin
      cond_taken = 1'b1;
      target     = RsData;
    end else begin
      case (op)
        BR_BEQ:  cond_taken = Equal;
        BR_BNE:  cond_taken = !Equal;
        BR_BGEZ: cond_taken = !RsData[WIDTH-1];
        BR_BGTZ: cond_taken = !RsData[WIDTH-1] && (RsData != '0);
        BR_BLEZ: cond_taken = RsData[WIDTH-1] || (RsData == '0);
        BR_BLTZ: cond_taken = RsData[WIDTH-1];
        BR_J: begin
          cond_taken   = 1'b1;
          target       = PCPlus4;
          target[27:0] = {JTarget, 2'b00};
        end
        default: cond_taken = 1'b0;
      endcase
    end
  end

  // Stall sequencing: hazards are only evaluated in IDLE, WAIT just burns the remaining cycles
  always_comb begin
    state_next  = state;
    remain_next = remain;
    Stall       = 1'b0;
    resolve     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (active) begin
          if (stall_count != 2'd0) begin
            Stall       = 1'b1;
            remain_next = stall_count - 2'd1;
            state_next  = (stall_count > 2'd1) ? ST_WAIT : ST_IDLE;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (!active) begin
          remain_next = 2'd0;
          state_next  = ST_IDLE;
        end else begin
          remain_next = (remain == 2'd0) ? 2'd0 : remain - 2'd1;
          if (remain <= 2'd1) state_next = ST_IDLE;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        remain_next = 2'd0;
      end
    endcase
    // Front end must run free the moment reset is raised, even mid-stall
    if (Reset) begin
      Stall   = 1'b0;
      resolve = 1'b0;
    end
  end

  assign PCSrc        = resolve && cond_taken;
  assign Flush        = PCSrc;
  assign BranchTarget = active ? target : '0;

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      remain <= 2'd0;
    end else begin
      state  <= state_next;
      remain <= remain_next;
    end
  end

  // Saturating statistics counters, bumped on each resolution cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BranchCount <= '0;
      TakenCount  <= '0;
    end else if (resolve) begin
      if (BranchCount != '1) BranchCount <= BranchCount + CNT_WIDTH'(1);
      if (PCSrc && (TakenCount != '1)) TakenCount <= TakenCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
module tb_branch_resolver;

  localparam int W    = 32;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [2:0]    BranchOp;
  logic          JumpReg, Equal;
  logic [W-1:0]  RsData, PCPlus4, Imm;
  logic [25:0]   JTarget;
  logic [4:0]    ID_Rs, ID_Rt, IDEX_Rd, EXMEM_Rd;
  logic          IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead;
  logic          Stall, PCSrc, Flush;
  logic [W-1:0]  BranchTarget;
  logic [CW-1:0] BranchCount, TakenCount;

  int checks = 0;
  int errors = 0;
  int exp_bc = 0;
  int exp_tc = 0;

  typedef struct {
    logic [2:0]  op;
    bit          jr, eq;
    logic [31:0] rs, pc4, imm;
    logic [25:0] jt;
    logic [4:0]  id_rs, id_rt;
    bit          idex_rw, idex_mr;
    logic [4:0]  idex_rd;
    bit          exmem_mr;
    logic [4:0]  exmem_rd;
    bit          e_stall, e_pcsrc;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t tbl[$];

  always #5 Clk = ~Clk;

  branch_resolver #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .BranchOp(BranchOp), .JumpReg(JumpReg), .Equal(Equal),
    .RsData(RsData), .PCPlus4(PCPlus4), .Imm(Imm), .JTarget(JTarget),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rd(IDEX_Rd), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
    .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Flush(Flush),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  function automatic vec_t mkv(input logic [2:0] op, input bit jr, input bit eq,
                               input logic [31:0] rs, input logic [31:0] pc4, input logic [31:0] imm,
                               input logic [25:0] jt, input logic [4:0] id_rs, input logic [4:0] id_rt,
                               input bit idex_rw, input bit idex_mr, input logic [4:0] idex_rd,
                               input bit exmem_mr, input logic [4:0] exmem_rd,
                               input bit e_stall, input bit e_pcsrc, input logic [31:0] e_tgt);
    vec_t v;
    v.op = op; v.jr = jr; v.eq = eq; v.rs = rs; v.pc4 = pc4; v.imm = imm; v.jt = jt;
    v.id_rs = id_rs; v.id_rt = id_rt; v.idex_rw = idex_rw; v.idex_mr = idex_mr;
    v.idex_rd = idex_rd; v.exmem_mr = exmem_mr; v.exmem_rd = exmem_rd;
    v.e_stall = e_stall; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    BranchOp = 3'd0; JumpReg = 1'b0; Equal = 1'b0; RsData = '0; PCPlus4 = '0; Imm = '0;
    JTarget = '0; ID_Rs = '0; ID_Rt = '0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
    IDEX_Rd = '0; EXMEM_MemRead = 1'b0; EXMEM_Rd = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    BranchOp = v.op; JumpReg = v.jr; Equal = v.eq; RsData = v.rs; PCPlus4 = v.pc4; Imm = v.imm;
    JTarget = v.jt; ID_Rs = v.id_rs; ID_Rt = v.id_rt; IDEX_RegWrite = v.idex_rw;
    IDEX_MemRead = v.idex_mr; IDEX_Rd = v.idex_rd; EXMEM_MemRead = v.exmem_mr; EXMEM_Rd = v.exmem_rd;
  endtask

  // Called at posedge+1: checks combinational outputs mid-cycle, then counters after the edge
  task automatic tick_check(input string tag, input bit e_stall, input bit e_res, input bit e_pcsrc,
                            input bit chk_tgt, input logic [31:0] e_tgt);
    #2;
    chk({tag, ".stall"}, 32'(Stall), 32'(e_stall));
    chk({tag, ".pcsrc"}, 32'(PCSrc), 32'(e_pcsrc));
    chk({tag, ".flush"}, 32'(Flush), 32'(e_pcsrc));
    if (chk_tgt) chk({tag, ".target"}, BranchTarget, e_tgt);
    if (e_res && exp_bc < CMAX) exp_bc++;
    if (e_pcsrc && exp_tc < CMAX) exp_tc++;
    @(posedge Clk); #1;
    chk({tag, ".bcount"}, 32'(BranchCount), 32'(exp_bc));
    chk({tag, ".tcount"}, 32'(TakenCount), 32'(exp_tc));
  endtask

  // Reference model, straight from the operational rules
  function automatic bit ref_hit(input logic [4:0] rd);
    bit rs_used, rt_used;
    rs_used = JumpReg || (BranchOp >= 3'd1 && BranchOp <= 3'd6);
    rt_used = !JumpReg && (BranchOp == 3'd1 || BranchOp == 3'd2);
    return (rd != 5'd0) && ((rs_used && rd == ID_Rs) || (rt_used && rd == ID_Rt));
  endfunction

  function automatic int ref_stalls();
    if (IDEX_MemRead && ref_hit(IDEX_Rd)) return 2;
    if (IDEX_RegWrite && ref_hit(IDEX_Rd)) return 1;
    if (EXMEM_MemRead && ref_hit(EXMEM_Rd)) return 1;
    return 0;
  endfunction

  function automatic bit ref_taken();
    if (JumpReg || BranchOp == 3'd7) return 1'b1;
    case (BranchOp)
      3'd1: return Equal;
      3'd2: return !Equal;
      3'd3: return $signed(RsData) >= 0;
      3'd4: return $signed(RsData) > 0;
      3'd5: return $signed(RsData) <= 0;
      3'd6: return $signed(RsData) < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target();
    if (JumpReg) return RsData;
    if (BranchOp == 3'd0) return 32'd0;
    if (BranchOp == 3'd7) return (PCPlus4 & 32'hF000_0000) | ({6'd0, JTarget} * 32'd4);
    return PCPlus4 + Imm * 32'd4;
  endfunction

  initial begin
    int hold;
    bit prev_stall, act, e_stall, e_res, e_pc;
    int c;
    logic [15:0] r16;

    clear_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("reset.stall", 32'(Stall), 32'd0);
    chk("reset.pcsrc", 32'(PCSrc), 32'd0);
    chk("reset.flush", 32'(Flush), 32'd0);
    chk("reset.target", BranchTarget, 32'd0);
    chk("reset.bcount", 32'(BranchCount), 32'd0);
    chk("reset.tcount", 32'(TakenCount), 32'd0);

    //             op jr eq rs            pc4           imm           jt          rs rt rw mr xrd mm mrd  st pc tgt
    tbl.push_back(mkv(1, 0, 1, 32'h0,        32'h100,      32'h4,        26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h110));
    tbl.push_back(mkv(2, 0, 1, 32'h0,        32'h100,      32'h4,        26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(3, 0, 0, 32'h0,        32'h200,      32'hFFFFFFFE, 26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h1F8));
    tbl.push_back(mkv(4, 0, 0, 32'h0,        32'h200,      32'h8,        26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(5, 0, 0, 32'h0,        32'h300,      32'h1,        26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h304));
    tbl.push_back(mkv(6, 0, 0, 32'h7FFFFFFF, 32'h300,      32'h1,        26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(6, 1, 0, 32'h00400020, 32'h300,      32'h1,        26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h00400020));
    tbl.push_back(mkv(7, 0, 0, 32'h0,        32'h10000004, 32'h0,        26'h10,      1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h10000040));
    tbl.push_back(mkv(0, 0, 1, 32'h0,        32'h500,      32'h3,        26'h0,       1, 2, 1, 1, 1, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(1, 0, 1, 32'h0,        32'h40,       32'h0,        26'h0,       0, 0, 1, 1, 0, 1, 0, 0, 1, 32'h40));
    tbl.push_back(mkv(7, 0, 0, 32'h0,        32'h20000000, 32'h0,        26'h3FFFFFF, 3, 3, 1, 1, 3, 0, 0, 0, 1, 32'h2FFFFFFC));
    tbl.push_back(mkv(3, 0, 0, 32'h80000000, 32'h600,      32'h2,        26'h0,       1, 4, 1, 0, 4, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(2, 0, 0, 32'h0,        32'h600,      32'h2,        26'h0,       6, 7, 0, 0, 0, 1, 7, 1, 0, 32'h0));
    tbl.push_back(mkv(0, 1, 0, 32'h1234,     32'h600,      32'h2,        26'h0,       9, 0, 0, 0, 0, 1, 9, 1, 0, 32'h0));
    tbl.push_back(mkv(1, 0, 1, 32'h0,        32'h600,      32'h2,        26'h0,      10, 11, 1, 0, 11, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mkv(5, 0, 0, 32'hFFFFFFFF, 32'h0,        32'h8000,     26'h0,       1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h20000));

    foreach (tbl[i]) begin
      apply_vec(tbl[i]);
      act = (tbl[i].op != 3'd0) || tbl[i].jr;
      tick_check($sformatf("vec%0d", i), tbl[i].e_stall, act && !tbl[i].e_stall, tbl[i].e_pcsrc,
                 tbl[i].e_pcsrc || !act, tbl[i].e_tgt);
    end

    // Load-use on rs: two stall cycles, then resolve with wrap-around target
    clear_inputs();
    BranchOp = 3'd1; Equal = 1'b1; ID_Rs = 5'd5; ID_Rt = 5'd6;
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd5; PCPlus4 = 32'h0; Imm = 32'hFFFFFFFF;
    tick_check("lu0", 1, 0, 0, 0, 0);
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_Rd = 5'd0; EXMEM_MemRead = 1'b1; EXMEM_Rd = 5'd5;
    tick_check("lu1", 1, 0, 0, 0, 0);
    EXMEM_MemRead = 1'b0; EXMEM_Rd = 5'd0;
    tick_check("lu2", 0, 1, 1, 1, 32'hFFFFFFFC);

    // bltz behind an ALU producer: one stall, then taken
    clear_inputs();
    BranchOp = 3'd6; RsData = 32'h80000000; ID_Rs = 5'd2; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd2;
    PCPlus4 = 32'h1000; Imm = 32'h10;
    tick_check("bl0", 1, 0, 0, 0, 0);
    IDEX_RegWrite = 1'b0;
    tick_check("bl1", 0, 1, 1, 1, 32'h1040);

    // Instruction vanishes while waiting: no resolution, back to IDLE
    clear_inputs();
    BranchOp = 3'd1; Equal = 1'b1; ID_Rs = 5'd5; IDEX_MemRead = 1'b1; IDEX_Rd = 5'd5;
    tick_check("dw0", 1, 0, 0, 0, 0);
    clear_inputs();
    @(posedge Clk); #1;
    chk("dw1.bcount", 32'(BranchCount), 32'(exp_bc));
    chk("dw1.tcount", 32'(TakenCount), 32'(exp_tc));
    tick_check("dw2", 0, 0, 0, 1, 32'h0);
    BranchOp = 3'd2; Equal = 1'b0;
    tick_check("dw3", 0, 1, 1, 1, 32'h0);

    // Reset in the middle of WAIT
    clear_inputs();
    BranchOp = 3'd1; Equal = 1'b1; ID_Rs = 5'd5; IDEX_MemRead = 1'b1; IDEX_Rd = 5'd5;
    tick_check("rw0", 1, 0, 0, 0, 0);
    #2;
    chk("rw.wait_stall", 32'(Stall), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rw.stall", 32'(Stall), 32'd0);
    chk("rw.bcount", 32'(BranchCount), 32'd0);
    chk("rw.tcount", 32'(TakenCount), 32'd0);
    exp_bc = 0; exp_tc = 0;
    @(negedge Clk);
    Reset = 1'b0;
    clear_inputs();
    @(posedge Clk); #1;
    chk("rw.idle_stall", 32'(Stall), 32'd0);

    // Randomized traffic against the reference model; small counters exercise saturation
    hold = 0;
    prev_stall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        BranchOp = 3'($urandom_range(0, 7));
        JumpReg  = ($urandom_range(0, 5) == 0);
        Equal    = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0: RsData = 32'h0;
          1: RsData = 32'h80000000;
          2: RsData = 32'h7FFFFFFF;
          3: RsData = 32'hFFFFFFFF;
          default: RsData = $urandom;
        endcase
        PCPlus4 = $urandom & 32'hFFFFFFFC;
        r16     = 16'($urandom);
        Imm     = {{16{r16[15]}}, r16};
        JTarget = 26'($urandom);
        ID_Rs   = 5'($urandom_range(0, 3));
        ID_Rt   = 5'($urandom_range(0, 3));
      end
      IDEX_RegWrite = 1'($urandom_range(0, 1));
      IDEX_MemRead  = 1'($urandom_range(0, 1));
      IDEX_Rd       = 5'($urandom_range(0, 3));
      EXMEM_MemRead = 1'($urandom_range(0, 1));
      EXMEM_Rd      = 5'($urandom_range(0, 3));

      act = (BranchOp != 3'd0) || JumpReg;
      e_stall = 1'b0; e_res = 1'b0; e_pc = 1'b0;
      if (hold > 0) begin
        e_stall = 1'b1;
        hold--;
      end else if (act) begin
        c = ref_stalls();
        if (c > 0) begin
          e_stall = 1'b1;
          hold = c - 1;
        end else begin
          e_res = 1'b1;
          e_pc  = ref_taken();
        end
      end
      tick_check($sformatf("rnd%0d", n), e_stall, e_res, e_pc, e_pc || !act, ref_target());
      prev_stall = e_stall;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
